countdown_display: RTL



---
 rtl/countdown_display_pkg.sv | 42 ++++
 rtl/countdown_display_bin2bcd8_seq.sv | 59 +++++
 rtl/countdown_display.sv | 116 +++++++++++
 3 files changed

// File: rtl/countdown_display_pkg.sv
// Shared types and 7-segment glyph tables for the countdown display slice.
package countdown_display_pkg;

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    // Segment order is g..a, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] GLYPH_DASH  = 4'hE;
    localparam logic [3:0] GLYPH_BLANK = 4'hF;

    function automatic logic [6:0] glyph_seg(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:       s = SEG_0;
            4'd1:       s = SEG_1;
            4'd2:       s = SEG_2;
            4'd3:       s = SEG_3;
            4'd4:       s = SEG_4;
            4'd5:       s = SEG_5;
            4'd6:       s = SEG_6;
            4'd7:       s = SEG_7;
            4'd8:       s = SEG_8;
            4'd9:       s = SEG_9;
            GLYPH_DASH: s = SEG_DASH;
            default:    s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/countdown_display_bin2bcd8_seq.sv
// Sequential double-dabble: 8-bit binary to hundreds/tens/ones BCD in 8 cycles.
module bin2bcd8_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [1:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [7:0] shift_q;
    logic [9:0] bcd_q;
    logic [9:0] bcd_adj;
    logic [2:0] cnt_q;
    logic       busy_q;
    logic       done_q;

    // Hundreds never exceeds 2 for an 8-bit input, so it needs no add-3.
    always_comb begin
        bcd_adj = bcd_q;
        if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q) begin
                {bcd_q, shift_q} <= {bcd_adj[8:0], shift_q, 1'b0};
                cnt_q            <= cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end else if (start) begin
                shift_q <= bin;
                bcd_q   <= '0;
                cnt_q   <= 3'd7;
                busy_q  <= 1'b1;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hundreds = bcd_q[9:8];
    assign tens     = bcd_q[7:4];
    assign ones     = bcd_q[3:0];

endmodule

// File: rtl/countdown_display.sv
// Two-digit multiplexed 7-segment display of the countdown value, with
// change-triggered BCD conversion and leading-zero / overflow handling.
//
// state | meaning
// IDLE  | watching num_in; start conversion on change or after reset
// CONV  | double-dabble running in bin2bcd8_seq
// LOAD  | latch glyph codes into display registers, pulse bcd_valid
module countdown_display
    import countdown_display_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] num_in,
    output logic [6:0] seg,
    output logic [1:0] dig_sel,
    output logic       busy,
    output logic       bcd_valid
);

    localparam int              SCAN_W    = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  last_val_q;
    logic        force_q;
    logic        start;
    logic        conv_busy, conv_done;
    logic [1:0]  hundreds;
    logic [3:0]  tens, ones;
    logic [3:0]  tens_code_q, ones_code_q;
    logic        bcd_valid_q;
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [1:0]  dig_sel_q;

    assign start = (state_q == IDLE) && (force_q || (num_in != last_val_q));

    bin2bcd8_seq u_bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (num_in),
        .busy     (conv_busy),
        .done     (conv_done),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONV;
            CONV:    if (conv_done) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_val_q <= '0;
            force_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            if (start) begin
                last_val_q <= num_in;
                force_q    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_code_q <= GLYPH_BLANK;
            ones_code_q <= GLYPH_BLANK;
            bcd_valid_q <= 1'b0;
        end else begin
            bcd_valid_q <= 1'b0;
            if (state_q == LOAD) begin
                bcd_valid_q <= 1'b1;
                if (hundreds != 2'd0) begin
                    tens_code_q <= GLYPH_DASH;
                    ones_code_q <= GLYPH_DASH;
                end else if (tens == 4'd0) begin
                    tens_code_q <= GLYPH_BLANK;
                    ones_code_q <= ones;
                end else begin
                    tens_code_q <= tens;
                    ones_code_q <= ones;
                end
            end
        end
    end

    // Free-running digit scan, unrelated to conversion activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            dig_sel_q  <= 2'b01;
        end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            dig_sel_q  <= {dig_sel_q[0], dig_sel_q[1]};
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
        end
    end

    assign seg       = glyph_seg(dig_sel_q[1] ? tens_code_q : ones_code_q);
    assign dig_sel   = dig_sel_q;
    assign busy      = (state_q != IDLE) | conv_busy;
    assign bcd_valid = bcd_valid_q;

endmodule
